// File: rtl/pixel_layer_scheduler_if.sv
// pixel_layer_scheduler_if: request, sprite-ROM and result signals of the pixel layer scheduler.
// Revision 1.0
`default_nettype none

interface pixel_layer_scheduler_if;
  logic        pix_start;
  logic        ready;
  logic [9:0]  draw_x;
  logic [9:0]  draw_y;
  logic [5:0]  layer_hit;
  logic [9:0]  pacman_pos_x;
  logic [9:0]  pacman_pos_y;
  logic [9:0]  blinky_pos_x;
  logic [9:0]  blinky_pos_y;
  logic [3:0]  pacman_sprite;
  logic [3:0]  blinky_sprite;
  logic [3:0]  scoreboard_sprite;
  logic        rom_req;
  logic [2:0]  rom_sel;
  logic [17:0] rom_addr;
  logic        rom_gnt;
  logic [3:0]  rom_data;
  logic        pix_valid;
  logic [2:0]  pix_layer;
  logic [3:0]  pix_code;

  // Environment side: issues pixels, serves the ROM, consumes results.
  modport master (
    output pix_start, draw_x, draw_y, layer_hit,
           pacman_pos_x, pacman_pos_y, blinky_pos_x, blinky_pos_y,
           pacman_sprite, blinky_sprite, scoreboard_sprite,
           rom_gnt, rom_data,
    input  ready, rom_req, rom_sel, rom_addr, pix_valid, pix_layer, pix_code
  );

  // Scheduler side.
  modport slave (
    input  pix_start, draw_x, draw_y, layer_hit,
           pacman_pos_x, pacman_pos_y, blinky_pos_x, blinky_pos_y,
           pacman_sprite, blinky_sprite, scoreboard_sprite,
           rom_gnt, rom_data,
    output ready, rom_req, rom_sel, rom_addr, pix_valid, pix_layer, pix_code
  );
endinterface

`default_nettype wire

// File: rtl/pixel_layer_scheduler.sv
// pixel_layer_scheduler: walks the hit layers of one pixel through a shared sprite ROM, keeps the top opaque code.
// Revision 1.0
`default_nettype none

module pixel_layer_scheduler (
  input  wire logic               clk,
  input  wire logic               rst,
  pixel_layer_scheduler_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      state;
  logic [9:0]  x, y, pac_x, pac_y, bli_x, bli_y;
  logic [3:0]  pac_spr, bli_spr, sb_spr;
  logic [5:0]  pending;
  logic [2:0]  cur;
  logic [2:0]  res_layer;
  logic [3:0]  res_code;

  function automatic logic [17:0] addr_of(
    input logic [2:0] l,
    input logic [9:0] dx, dy, px, py, bx, by,
    input logic [3:0] ps, bs, ss
  );
    logic [17:0] xx, yy, r;
    xx = 18'(dx);
    yy = 18'(dy);
    case (l)
      3'd0:    r = 18'd336 * (yy - 18'd72) + (xx - 18'd72);
      3'd1:    r = 18'd72 * (yy % 18'd12) + xx % 18'd12;
      3'd2:    r = 18'd72 * (yy % 18'd12) + xx % 18'd12 + 18'd48;
      3'd3:    r = 18'd216 * (yy - 18'(py) - 18'd6) + (xx - 18'(px)) + 18'd24 * 18'(ps);
      3'd4:    r = 18'd192 * (yy - 18'(by) - 18'd6) + (xx - 18'(bx)) + 18'd24 * 18'(bs);
      3'd5:    r = 18'd192 * ((yy + 18'd6) % 18'd12) + xx % 18'd12 + 18'd12 * 18'(ss);
      default: r = 18'd0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] low_of(input logic [5:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  function automatic logic opaque(input logic [2:0] l, input logic [3:0] d);
    logic o;
    case (l)
      3'd0, 3'd5: o = (d != 4'd0);
      3'd1, 3'd2: o = (d == 4'd2);
      3'd3:       o = (d == 4'd6) || (d == 4'd7);
      3'd4:       o = (d == 4'd0) || (d == 4'd1) || (d == 4'd11);
      default:    o = 1'b0;
    endcase
    return o;
  endfunction

  logic [5:0]  rest;
  logic [2:0]  first_layer, next_layer;
  logic [17:0] first_addr, next_addr;
  logic [2:0]  new_layer;
  logic [3:0]  new_code;

  always_comb begin
    rest        = pending & ~(6'b000001 << cur);
    first_layer = low_of(bus.layer_hit);
    next_layer  = low_of(rest);
    // First address comes straight from the inputs, since the latches fill on the same edge.
    first_addr  = addr_of(first_layer, bus.draw_x, bus.draw_y,
                          bus.pacman_pos_x, bus.pacman_pos_y,
                          bus.blinky_pos_x, bus.blinky_pos_y,
                          bus.pacman_sprite, bus.blinky_sprite, bus.scoreboard_sprite);
    next_addr   = addr_of(next_layer, x, y, pac_x, pac_y, bli_x, bli_y,
                          pac_spr, bli_spr, sb_spr);
    new_layer   = res_layer;
    new_code    = res_code;
    if (opaque(cur, bus.rom_data)) begin
      new_layer = cur;
      new_code  = bus.rom_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_IDLE;
      bus.ready     <= 1'b1;
      bus.rom_req   <= 1'b0;
      bus.rom_sel   <= 3'd0;
      bus.rom_addr  <= 18'd0;
      bus.pix_valid <= 1'b0;
      bus.pix_layer <= 3'd7;
      bus.pix_code  <= 4'd0;
      pending       <= 6'd0;
      cur           <= 3'd0;
      res_layer     <= 3'd7;
      res_code      <= 4'd0;
      x       <= 10'd0;  y       <= 10'd0;
      pac_x   <= 10'd0;  pac_y   <= 10'd0;
      bli_x   <= 10'd0;  bli_y   <= 10'd0;
      pac_spr <= 4'd0;   bli_spr <= 4'd0;  sb_spr <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.pix_start) begin
            x       <= bus.draw_x;          y       <= bus.draw_y;
            pac_x   <= bus.pacman_pos_x;    pac_y   <= bus.pacman_pos_y;
            bli_x   <= bus.blinky_pos_x;    bli_y   <= bus.blinky_pos_y;
            pac_spr <= bus.pacman_sprite;   bli_spr <= bus.blinky_sprite;
            sb_spr  <= bus.scoreboard_sprite;
            pending   <= bus.layer_hit;
            res_layer <= 3'd7;
            res_code  <= 4'd0;
            bus.ready <= 1'b0;
            if (bus.layer_hit != 6'd0) begin
              cur          <= first_layer;
              bus.rom_req  <= 1'b1;
              bus.rom_sel  <= first_layer;
              bus.rom_addr <= first_addr;
              state        <= S_ISSUE;
            end else begin
              bus.pix_valid <= 1'b1;
              bus.pix_layer <= 3'd7;
              bus.pix_code  <= 4'd0;
              state         <= S_DONE;
            end
          end
        end
        S_ISSUE: begin
          if (bus.rom_gnt) begin
            bus.rom_req <= 1'b0;
            state       <= S_WAIT;
          end
        end
        S_WAIT: begin
          pending   <= rest;
          res_layer <= new_layer;
          res_code  <= new_code;
          if (rest != 6'd0) begin
            cur          <= next_layer;
            bus.rom_req  <= 1'b1;
            bus.rom_sel  <= next_layer;
            bus.rom_addr <= next_addr;
            state        <= S_ISSUE;
          end else begin
            bus.pix_valid <= 1'b1;
            bus.pix_layer <= new_layer;
            bus.pix_code  <= new_code;
            state         <= S_DONE;
          end
        end
        default: begin
          bus.pix_valid <= 1'b0;
          bus.ready     <= 1'b1;
          state         <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
